// File: rtl/pipe_chain.sv
// Elastic pipeline chain: per-stage valid/data registers with ready_go/allow handshaking,
// cascaded flush, and a registered occupancy count of live stages.
module pipe_chain #(
  parameter int STAGES = 4,
  parameter int WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_allow,
  input  logic [STAGES-1:0]          stage_ready_go,
  input  logic [STAGES*WIDTH-1:0]    stage_result,
  input  logic [STAGES-1:0]          flush,
  output logic [STAGES-1:0]          stage_valid,
  output logic [STAGES*WIDTH-1:0]    stage_data,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(STAGES+1)-1:0] occupancy
);

  localparam int CNT_W = $clog2(STAGES+1);

  logic [STAGES-1:0]       valid_q, valid_d;
  logic [STAGES*WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]        occ_q;

  logic [STAGES-1:0]       go, allow, kill, in_vld;
  logic [STAGES*WIDTH-1:0] in_pay;
  logic                    any_flush;

  function automatic logic [CNT_W-1:0] popcount(input logic [STAGES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < STAGES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  assign go        = valid_q & stage_ready_go;
  assign any_flush = |flush;

  // Stage k is fed by stage k-1's result; stage 0 by the upstream port.
  assign in_vld = {go[STAGES-2:0], in_valid & ~any_flush};
  assign in_pay = {stage_result[(STAGES-1)*WIDTH-1:0], in_data};

  // allow ripples back from out_ready; kill ripples down from the oldest flushed stage.
  always_comb begin : handshake
    logic a;
    logic f;
    allow = '0;
    kill  = '0;
    a     = out_ready;
    f     = 1'b0;
    for (int k = STAGES-1; k >= 0; k--) begin
      a        = ~valid_q[k] | (stage_ready_go[k] & a);
      allow[k] = a;
      f        = f | flush[k];
      kill[k]  = f;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < STAGES; k++) begin
      if (kill[k]) begin
        valid_d[k] = 1'b0;
      end else if (allow[k]) begin
        valid_d[k] = in_vld[k];
        if (in_vld[k]) data_d[k*WIDTH +: WIDTH] = in_pay[k*WIDTH +: WIDTH];
      end
    end
  end

  // Stage register boundary
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      data_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= popcount(valid_d);
    end
  end

  assign in_allow    = allow[0] & ~any_flush;
  assign out_valid   = go[STAGES-1];
  assign out_data    = stage_result[(STAGES-1)*WIDTH +: WIDTH];
  assign stage_valid = valid_q;
  assign stage_data  = data_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboarded bench for pipe_chain: directed streams push expected exits into a queue,
// a negedge monitor pops and compares every handshake on the output side.
module tb_pipe_chain;
  localparam int STAGES = 4;
  localparam int WIDTH  = 32;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic                    in_valid;
  logic [WIDTH-1:0]        in_data;
  logic                    in_allow;
  logic [STAGES-1:0]       stage_ready_go;
  logic [STAGES*WIDTH-1:0] stage_result;
  logic [STAGES-1:0]       flush;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES*WIDTH-1:0] stage_data;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic                    out_ready;
  logic [2:0]              occupancy;
  bit                      plus1;

  int n_pass  = 0;
  int n_total = 0;
  logic [WIDTH-1:0] exp_q[$];

  pipe_chain #(.STAGES(STAGES), .WIDTH(WIDTH)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_allow(in_allow), .stage_ready_go(stage_ready_go), .stage_result(stage_result),
    .flush(flush), .stage_valid(stage_valid), .stage_data(stage_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  always_comb begin
    stage_result = stage_data;
    if (plus1)
      for (int k = 0; k < STAGES; k++)
        stage_result[k*WIDTH +: WIDTH] = stage_data[k*WIDTH +: WIDTH] + 32'd1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input bit do_push, input logic [WIDTH-1:0] exp);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_allow) begin
        done = 1'b1;
        if (do_push) exp_q.push_back(exp);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL send_timeout: got no in_allow for payload %0h", d);
    end
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got %0h expected nothing", out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        check("out_data", out_data, e);
      end
    end
  end

  initial begin
    resetn         = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    stage_ready_go = '1;
    flush          = '0;
    out_ready      = 1'b1;
    plus1          = 1'b0;

    #3;
    check("rst_valid", stage_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_in_allow", in_allow, 1);
    check("rst_out_valid", out_valid, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Basic stream, latency and peak occupancy
    send(32'h11, 1'b1, 32'h11);
    send(32'h22, 1'b1, 32'h22);
    send(32'h33, 1'b1, 32'h33);
    @(negedge clk);
    check("stream_occ3", occupancy, 3);
    check("stream_not_yet", out_valid, 0);
    tick();
    @(negedge clk);
    check("stream_first_out", out_valid, 1);
    repeat (6) tick();
    check("stream_empty", occupancy, 0);

    // Backpressure: fill, hold, drain
    out_ready = 1'b0;
    send(32'hA0, 1'b1, 32'hA0);
    send(32'hA1, 1'b1, 32'hA1);
    send(32'hA2, 1'b1, 32'hA2);
    send(32'hA3, 1'b1, 32'hA3);
    in_valid = 1'b1;
    in_data  = 32'hBB;
    @(negedge clk);
    check("full_in_allow", in_allow, 0);
    check("full_occ", occupancy, 4);
    check("full_valid", stage_valid, 4'hF);
    check("full_data", stage_data, {32'hA0, 32'hA1, 32'hA2, 32'hA3});
    repeat (3) tick();
    @(negedge clk);
    check("hold_data", stage_data, {32'hA0, 32'hA1, 32'hA2, 32'hA3});
    check("hold_in_allow", in_allow, 0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_consec", out_valid, 1);
      tick();
    end
    @(negedge clk);
    check("drain_done", out_valid, 0);
    check("drain_occ", occupancy, 0);
    tick();

    // Mid-stream stall of stage 2
    fork
      begin
        for (int i = 0; i < 6; i++) send(32'hB0 + 32'(i), 1'b1, 32'hB0 + 32'(i));
      end
      begin
        repeat (4) tick();
        stage_ready_go = 4'b1011;
        tick();
        @(negedge clk);
        check("stall_bubble", stage_valid, 4'b0111);
        check("stall_in_allow", in_allow, 0);
        tick();
        tick();
        stage_ready_go = 4'b1111;
      end
    join
    repeat (10) tick();
    check("stall_occ", occupancy, 0);
    check("stall_noloss", exp_q.size(), 0);

    // Flush of stages 0..2 on a full chain
    out_ready = 1'b0;
    send(32'hC0, 1'b1, 32'hC0);
    send(32'hC1, 1'b0, 32'h0);
    send(32'hC2, 1'b0, 32'h0);
    send(32'hC3, 1'b0, 32'h0);
    flush    = 4'b0100;
    in_valid = 1'b1;
    in_data  = 32'hCC;
    @(negedge clk);
    check("flush_in_allow", in_allow, 0);
    tick();
    flush    = '0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", stage_valid, 4'b1000);
    check("flush_occ", occupancy, 1);
    check("flush_s3", stage_data[127:96], 32'hC0);
    tick();
    out_ready = 1'b1;
    repeat (3) tick();
    check("flush_empty", occupancy, 0);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    send(32'hD0, 1'b0, 32'h0);
    send(32'hD1, 1'b0, 32'h0);
    send(32'hD2, 1'b0, 32'h0);
    send(32'hD3, 1'b0, 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_valid", stage_valid, 0);
    check("arst_occ", occupancy, 0);
    check("arst_data", stage_data, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_allow", in_allow, 1);
    tick();
    resetn = 1'b1;
    tick();
    send(32'h55, 1'b1, 32'h55);
    tick();
    tick();
    @(negedge clk);
    check("lat55_early", out_valid, 0);
    tick();
    @(negedge clk);
    check("lat55_out", out_valid, 1);
    repeat (3) tick();

    // Per-stage transform: each stage adds one
    plus1 = 1'b1;
    send(32'h10, 1'b1, 32'h14);
    repeat (6) tick();
    plus1 = 1'b0;
    check("plus_occ", occupancy, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_chain.md
PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 The block SHALL have parameter STAGES, default 4 (legal 2..8), giving the number of pipeline register stages; stage 0 is the youngest.
REQ-002 The block SHALL have parameter WIDTH, default 32 (legal 1..512), giving the payload bits per stage.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  upstream offers a payload.
REQ-006 in_data  in  WIDTH  upstream payload.
REQ-007 in_allow  out  1  stage 0 accepts this cycle.
REQ-008 stage_ready_go  in  STAGES  bit k means stage k logic has finished.
REQ-009 stage_result  in  STAGES*WIDTH  slice k is the stage k output payload, forwarded to stage k+1.
REQ-010 flush  in  STAGES  bit k kills stages 0..k.
REQ-011 stage_valid  out  STAGES  bit k is the stage k valid register.
REQ-012 stage_data  out  STAGES*WIDTH  slice k is the stage k payload register.
REQ-013 out_valid  out  1  last stage is presenting a payload.
REQ-014 out_data  out  WIDTH  stage_result slice STAGES-1.
REQ-015 out_ready  in  1  downstream allow-in.
REQ-016 occupancy  out  $clog2(STAGES+1)  registered count of set stage_valid bits.

Function
REQ-017 go_k SHALL equal stage_valid[k] & stage_ready_go[k].
REQ-018 allow_k SHALL equal ~stage_valid[k] | (stage_ready_go[k] & allow_{k+1}), where allow_STAGES is out_ready.
REQ-019 out_valid SHALL equal go_{STAGES-1}, combinationally.
REQ-020 in_allow SHALL equal allow_0 & ~(|flush).
REQ-021 kill_k SHALL be the OR of flush[j] for j>=k.
REQ-022 On each edge where kill_k=1, stage_valid[k] SHALL become 0; kill SHALL have priority over all other updates.
REQ-023 For k>0 with kill_k=0 and allow_k=1, stage_valid[k] SHALL load go_{k-1} and stage_data slice k SHALL load stage_result slice k-1.
REQ-024 For stage 0 with kill_0=0 and allow_0=1, stage_valid[0] SHALL load in_valid & ~(|flush) and stage_data slice 0 SHALL load in_data.
REQ-025 When allow_k=0, stage k SHALL hold both valid and data.
REQ-026 Data registers SHALL load only when the incoming valid is 1.
REQ-027 A transfer out of stage k and a transfer into it on the same edge SHALL both complete, with no bubble.
REQ-028 Latency: with all ready_go=1 and out_ready=1, a payload accepted at edge t SHALL give out_valid=1 in the cycle after edge t+STAGES-1; throughput SHALL be 1 per cycle.
REQ-029 With out_ready=0, a full chain SHALL drop in_allow to 0 in the same cycle and lose no payload.
REQ-030 occupancy SHALL equal the popcount of the next-state stage_valid, registered, and SHALL track stage_valid every cycle.

Reset
REQ-031 resetn=0 SHALL clear stage_valid, stage_data and occupancy to 0 immediately, independent of clk.
REQ-032 While resetn=0, out_valid and in_allow SHALL read 0 and 1 respectively when out_ready=1; deassertion SHALL be synchronised externally.
REQ-033 Reset asserted mid-operation SHALL discard all payloads, with no partial update on the release edge.

Verification (STAGES=4, WIDTH=32, stage_result=stage_data unless stated)
REQ-034 Stream 0x11,0x22,0x33 with all ready_go=1 and out_ready=1 -> out_valid first high in the cycle after the 4th edge, values in order, occupancy peaks at 3.
REQ-035 Fill with 0xA0..0xA3 and hold out_ready=0 -> in_allow=0, occupancy=4, data held; then out_ready=1 -> 0xA0..0xA3 drain on consecutive cycles.
REQ-036 stage_ready_go[2]=0 for 3 cycles mid-stream -> stages 0..1 stall once full, stage 3 drains to a bubble, no reorder or loss.
REQ-037 Full chain, flush=4'b0100 for one cycle with in_valid=1 -> stages 0..2 invalid, stage 3 retained, input not accepted, occupancy=1.
REQ-038 resetn pulsed low between edges while full -> stage_valid=0 and occupancy=0 before the next edge; the first post-release payload 0x55 emerges with normal latency.
REQ-039 stage_result slice k = stage_data slice k + 1 -> input 0x10 exits as 0x14.
